writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage; sits directly upstream of the register file and drives its single write port (dst_reg, dst_reg_data, reg_write_enable).
- Accepts results from two producers, the ALU path and the load/memory path, using valid/ready handshakes.
- Buffers results in a small FIFO and retires at most one write per cycle.
- Optionally exposes a bypass lookup so decode can read results that are still pending and not yet written.

Parameters:
- ARCH_LEN, 32, data width (from constants_pkg)
- REG_FILE_LEN, 32, number of architectural registers; register index width is $clog2(REG_FILE_LEN)
- FIFO_DEPTH, 2, pending-result buffer depth; must be a power of 2, ≥2

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle
- alu_dst_reg  in  $clog2(REG_FILE_LEN)  ALU destination register
- alu_data  in  ARCH_LEN  ALU result
- mem_valid  in  1  load result offered
- mem_ready  out  1  load result accepted this cycle
- mem_dst_reg  in  $clog2(REG_FILE_LEN)  load destination register
- mem_data  in  ARCH_LEN  load result
- dst_reg  out  $clog2(REG_FILE_LEN)  to register file
- dst_reg_data  out  ARCH_LEN  to register file
- reg_write_enable  out  1  to register file; one-cycle pulse per retired write
- fwd_reg_1, fwd_reg_2  in  $clog2(REG_FILE_LEN)  bypass lookup indices
- fwd_hit_1, fwd_hit_2  out  1  a pending write to that register exists
- fwd_data_1, fwd_data_2  out  ARCH_LEN  youngest pending data for that register
- busy  out  1  FIFO or output register holds a pending write

Behaviour:
- Reset (rst=0, async):
  - FIFO pointers and count go to 0.
  - dst_reg=0, dst_reg_data=0, reg_write_enable=0, busy=0.
  - Results in flight at reset are discarded, with no partial write.
- Acceptance: at most one result enters per cycle.
  - mem_ready = !full.
  - alu_ready = !full && !mem_valid. The load path has fixed priority.
  - A transfer occurs when valid && ready at a posedge.
  - The ready signals depend only on registered state plus mem_valid; there is no combinational path from the pop.
- A result with dst_reg==0 is accepted (ready asserted as normal) but dropped. It is not enqueued and never pulses reg_write_enable.
- Retire: output register fields dst_reg, dst_reg_data, reg_write_enable.
  - Each posedge: if the FIFO is non-empty, pop the head into the output register and set reg_write_enable=1. Otherwise reg_write_enable=0.
  - If the FIFO is empty and a result is accepted that cycle, the result bypasses the FIFO straight into the output register.
  - Minimum latency is 1 cycle: a result accepted at edge N gives reg_write_enable=1 during the cycle after edge N.
  - The register file samples on the following negedge.
- Ordering: writes retire strictly in acceptance order. Back-to-back writes to the same register both retire, so the younger value wins in the register file.
- Full/empty:
  - full = count==FIFO_DEPTH.
  - A simultaneous push and pop when not full leaves count unchanged.
  - Push while full is impossible by construction.
  - Pointers wrap modulo FIFO_DEPTH.
- busy = (count!=0) || reg_write_enable.
- The assertion checks that popping when empty never occurs.

Optional Feature:
- Macro WB_FORWARD_EN.
- Defined:
  - fwd_hit_k=1 when fwd_reg_k!=0 and it matches the output register (while reg_write_enable=1) or any valid FIFO entry.
  - fwd_data_k is taken from the youngest match. FIFO tail-most entry is youngest; the output register is oldest.
  - The lookup is purely combinational from stored state; results accepted this cycle are not visible.
- Undefined: fwd_hit_k=0 and fwd_data_k=0 constantly; the ports remain present.

Decomposition:
- constants_pkg: ARCH_LEN, REG_FILE_LEN (existing).
- structure_pkg: typedef wb_entry_t {dst_reg, data}, plus the FIFO index typedef.
- One sub-module, wb_fifo: parameterised wb_entry_t storage with push/pop/full/empty/count, and entry-array visibility for the bypass search.

Test Plan:
1. Reset mid-traffic:
   - Stimulus: fill the FIFO with x5=0x11, x6=0x22, then pulse rst=0.
   - Required: outputs are 0 immediately (async), busy=0, and no reg_write_enable follows.
2. Single ALU write:
   - Stimulus: alu_valid=1, dst=x3, data=0xDEADBEEF, FIFO empty.
   - Required: alu_ready=1; during the next cycle reg_write_enable=1, dst_reg=3, dst_reg_data=0xDEADBEEF; in the cycle after, reg_write_enable=0.
3. Contention:
   - Stimulus: alu_valid and mem_valid both high for 1 cycle (alu x4=0x1, mem x7=0x2).
   - Required: mem accepted and alu_ready=0; the ALU is accepted next cycle; retirement order is x7 then x4.
4. Backpressure:
   - Stimulus: hold mem_valid high for 4 cycles with distinct data, FIFO_DEPTH=2.
   - Required: 4 writes retire in order over consecutive cycles, mem_ready never falsely high while full, and no data is lost or duplicated.
5. x0 drop:
   - Stimulus: alu dst=x0, data=0xFFFF.
   - Required: alu_ready=1, reg_write_enable stays 0, busy stays 0.
6. Forwarding (WB_FORWARD_EN):
   - Stimulus: enqueue x9=0xA then x9=0xB while stalled, set fwd_reg_1=9.
   - Required: fwd_hit_1=1, fwd_data_1=0xB; fwd_reg_2=0 gives fwd_hit_2=0.

Source files
------------

// File: rtl/constants_pkg.sv
// ---------------------------------------------------------------------------
// constants_pkg
// Architectural constants shared across the core.
//   ARCH_LEN     : datapath width in bits
//   REG_FILE_LEN : number of architectural registers
// ---------------------------------------------------------------------------
package constants_pkg;
  localparam int ARCH_LEN     = 32;
  localparam int REG_FILE_LEN = 32;
endpackage

// File: rtl/structure_pkg.sv
// ---------------------------------------------------------------------------
// structure_pkg
// Shared structures for the writeback stage.
//   REG_IDX_W     : register index width derived from REG_FILE_LEN
//   WB_FIFO_DEPTH : default depth of the pending-result buffer
//   wb_entry_t    : one pending register write {dst_reg, data}
//   fifo_idx_t    : index into the default-depth pending-result buffer
// ---------------------------------------------------------------------------
package structure_pkg;
  import constants_pkg::*;

  localparam int REG_IDX_W     = $clog2(REG_FILE_LEN);
  localparam int WB_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [REG_IDX_W-1:0] dst_reg;
    logic [ARCH_LEN-1:0]  data;
  } wb_entry_t;

  typedef logic [$clog2(WB_FIFO_DEPTH)-1:0] fifo_idx_t;
endpackage

// File: rtl/writeback_stage_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Small circular buffer of pending register writes. Besides the usual
// push/pop interface it exposes every slot ordered by age so the stage can
// search pending writes for operand bypass.
//   clk, rst_n          : clock, asynchronous active-low reset
//   push, push_entry    : enqueue one entry (never while full)
//   pop                 : dequeue the head (never while empty)
//   head                : oldest entry
//   full, empty, count  : occupancy
//   by_age[i]           : i-th oldest slot (0 = head)
//   age_valid[i]        : by_age[i] holds a live entry
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module wb_fifo
  import structure_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  wb_entry_t                    push_entry,
  input  logic                         pop,
  output wb_entry_t                    head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output wb_entry_t [DEPTH-1:0]        by_age,
  output logic [DEPTH-1:0]             age_valid
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // A simultaneous push and pop leaves the occupancy unchanged.
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Slots re-ordered from oldest (head) to youngest; slots beyond the
  // current occupancy are flagged invalid.
  always_comb begin
    by_age    = '0;
    age_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      by_age[i]    = mem_q[rd_ptr_q + PTR_W'(i)];
      age_valid[i] = (CNT_W'(i) < count_q);
    end
  end

  pop_never_when_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
  push_never_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule

// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
// Final pipeline stage. Accepts results from the load path and the ALU
// path, buffers them, and retires at most one register-file write per cycle
// in acceptance order.
//   clk, rst                          : clock, asynchronous active-low reset
//   mem_valid/ready, mem_dst_reg/data : load result handshake (priority)
//   alu_valid/ready, alu_dst_reg/data : ALU result handshake
//   dst_reg, dst_reg_data             : register file write port
//   reg_write_enable                  : one-cycle pulse per retired write
//   fwd_reg_k -> fwd_hit_k/fwd_data_k : bypass lookup of pending writes
//   busy                              : a write is still pending
// Optional feature macro: WB_FORWARD_EN enables the bypass lookup; without
// it the fwd_hit/fwd_data outputs are tied to zero.
// The ARCH_LEN/REG_FILE_LEN parameters must match constants_pkg, since the
// pending-entry structure is sized from that package.
// ---------------------------------------------------------------------------
module writeback_stage
  import structure_pkg::*;
#(
  parameter int ARCH_LEN     = constants_pkg::ARCH_LEN,
  parameter int REG_FILE_LEN = constants_pkg::REG_FILE_LEN,
  parameter int FIFO_DEPTH   = WB_FIFO_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            alu_valid,
  output logic                            alu_ready,
  input  logic [$clog2(REG_FILE_LEN)-1:0] alu_dst_reg,
  input  logic [ARCH_LEN-1:0]             alu_data,
  input  logic                            mem_valid,
  output logic                            mem_ready,
  input  logic [$clog2(REG_FILE_LEN)-1:0] mem_dst_reg,
  input  logic [ARCH_LEN-1:0]             mem_data,
  output logic [$clog2(REG_FILE_LEN)-1:0] dst_reg,
  output logic [ARCH_LEN-1:0]             dst_reg_data,
  output logic                            reg_write_enable,
  input  logic [$clog2(REG_FILE_LEN)-1:0] fwd_reg_1,
  input  logic [$clog2(REG_FILE_LEN)-1:0] fwd_reg_2,
  output logic                            fwd_hit_1,
  output logic                            fwd_hit_2,
  output logic [ARCH_LEN-1:0]             fwd_data_1,
  output logic [ARCH_LEN-1:0]             fwd_data_2,
  output logic                            busy
);
  localparam int REG_W = $clog2(REG_FILE_LEN);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  wb_entry_t                  fifo_head;
  wb_entry_t                  in_entry;
  wb_entry_t [FIFO_DEPTH-1:0] fifo_by_age;
  logic [FIFO_DEPTH-1:0]      fifo_age_valid;
  logic [CNT_W-1:0]           fifo_count;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       fifo_push;
  logic                       fifo_pop;
  logic                       mem_fire;
  logic                       alu_fire;
  logic                       in_keep;

  logic [REG_W-1:0]    dst_reg_q, dst_reg_d;
  logic [ARCH_LEN-1:0] dst_reg_data_q, dst_reg_data_d;
  logic                reg_write_enable_q, reg_write_enable_d;

  // Ready depends only on stored occupancy and mem_valid, never on the pop,
  // so there is no combinational loop through the retire path.
  assign mem_ready = !fifo_full;
  assign alu_ready = !fifo_full && !mem_valid;
  assign mem_fire  = mem_valid && mem_ready;
  assign alu_fire  = alu_valid && alu_ready;

  // Select the accepted result; writes to x0 are accepted but discarded.
  always_comb begin
    in_entry.dst_reg = mem_fire ? mem_dst_reg : alu_dst_reg;
    in_entry.data    = mem_fire ? mem_data : alu_data;
    in_keep          = (mem_fire || alu_fire) && (in_entry.dst_reg != '0);
  end

  // The head retires every cycle the buffer holds something. An accepted
  // result only enters the buffer when something older is still waiting;
  // otherwise it goes straight to the output register.
  always_comb begin
    fifo_pop           = !fifo_empty;
    fifo_push          = in_keep && !fifo_empty;
    dst_reg_d          = dst_reg_q;
    dst_reg_data_d     = dst_reg_data_q;
    reg_write_enable_d = 1'b0;
    if (fifo_pop) begin
      dst_reg_d          = fifo_head.dst_reg;
      dst_reg_data_d     = fifo_head.data;
      reg_write_enable_d = 1'b1;
    end else if (in_keep) begin
      dst_reg_d          = in_entry.dst_reg;
      dst_reg_data_d     = in_entry.data;
      reg_write_enable_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dst_reg_q          <= '0;
      dst_reg_data_q     <= '0;
      reg_write_enable_q <= 1'b0;
    end else begin
      dst_reg_q          <= dst_reg_d;
      dst_reg_data_q     <= dst_reg_data_d;
      reg_write_enable_q <= reg_write_enable_d;
    end
  end

  assign dst_reg          = dst_reg_q;
  assign dst_reg_data     = dst_reg_data_q;
  assign reg_write_enable = reg_write_enable_q;
  assign busy             = (fifo_count != '0) || reg_write_enable_q;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .push       (fifo_push),
    .push_entry (in_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .by_age     (fifo_by_age),
    .age_valid  (fifo_age_valid)
  );

`ifdef WB_FORWARD_EN
  // Search oldest to youngest so the last match wins: the output register
  // is the oldest pending write, the buffer tail the youngest. Only stored
  // state is searched; results accepted this cycle are not visible yet.
  always_comb begin
    fwd_hit_1  = 1'b0;
    fwd_data_1 = '0;
    fwd_hit_2  = 1'b0;
    fwd_data_2 = '0;
    if (reg_write_enable_q && (fwd_reg_1 != '0) && (dst_reg_q == fwd_reg_1)) begin
      fwd_hit_1  = 1'b1;
      fwd_data_1 = dst_reg_data_q;
    end
    if (reg_write_enable_q && (fwd_reg_2 != '0) && (dst_reg_q == fwd_reg_2)) begin
      fwd_hit_2  = 1'b1;
      fwd_data_2 = dst_reg_data_q;
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_age_valid[i] && (fwd_reg_1 != '0) && (fifo_by_age[i].dst_reg == fwd_reg_1)) begin
        fwd_hit_1  = 1'b1;
        fwd_data_1 = fifo_by_age[i].data;
      end
      if (fifo_age_valid[i] && (fwd_reg_2 != '0) && (fifo_by_age[i].dst_reg == fwd_reg_2)) begin
        fwd_hit_2  = 1'b1;
        fwd_data_2 = fifo_by_age[i].data;
      end
    end
  end
`else
  logic unused_fwd_inputs;

  assign fwd_hit_1         = 1'b0;
  assign fwd_hit_2         = 1'b0;
  assign fwd_data_1        = '0;
  assign fwd_data_2        = '0;
  assign unused_fwd_inputs = ^{fwd_reg_1, fwd_reg_2, fifo_by_age, fifo_age_valid};
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_writeback_stage
// Self-checking bench for writeback_stage. Expected register writes are
// pushed to a scoreboard queue when a result is offered and accepted; a
// negedge monitor pops and compares every retired write.
// ---------------------------------------------------------------------------
module tb_writeback_stage;
  localparam int DW = 32;
  localparam int RW = 5;

`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [RW-1:0] r;
    logic [DW-1:0] d;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          alu_valid = 1'b0;
  logic          alu_ready;
  logic [RW-1:0] alu_dst_reg = '0;
  logic [DW-1:0] alu_data = '0;
  logic          mem_valid = 1'b0;
  logic          mem_ready;
  logic [RW-1:0] mem_dst_reg = '0;
  logic [DW-1:0] mem_data = '0;
  logic [RW-1:0] dst_reg;
  logic [DW-1:0] dst_reg_data;
  logic          reg_write_enable;
  logic [RW-1:0] fwd_reg_1 = '0;
  logic [RW-1:0] fwd_reg_2 = '0;
  logic          fwd_hit_1;
  logic          fwd_hit_2;
  logic [DW-1:0] fwd_data_1;
  logic [DW-1:0] fwd_data_2;
  logic          busy;

  exp_t sb[$];
  exp_t mon_exp;
  int   compared = 0;
  int   mismatched = 0;

  writeback_stage dut (
    .clk              (clk),
    .rst              (rst),
    .alu_valid        (alu_valid),
    .alu_ready        (alu_ready),
    .alu_dst_reg      (alu_dst_reg),
    .alu_data         (alu_data),
    .mem_valid        (mem_valid),
    .mem_ready        (mem_ready),
    .mem_dst_reg      (mem_dst_reg),
    .mem_data         (mem_data),
    .dst_reg          (dst_reg),
    .dst_reg_data     (dst_reg_data),
    .reg_write_enable (reg_write_enable),
    .fwd_reg_1        (fwd_reg_1),
    .fwd_reg_2        (fwd_reg_2),
    .fwd_hit_1        (fwd_hit_1),
    .fwd_hit_2        (fwd_hit_2),
    .fwd_data_1       (fwd_data_1),
    .fwd_data_2       (fwd_data_2),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // Register-file side: every retired write must match the oldest expected.
  always @(negedge clk) begin
    if (rst && reg_write_enable) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL retire_unexpected: got x%0d=0x%08h, required no write", dst_reg, dst_reg_data);
      end else begin
        mon_exp = sb.pop_front();
        if ({dst_reg, dst_reg_data} !== {mon_exp.r, mon_exp.d}) begin
          mismatched++;
          $display("[TB] FAIL retire_order: got x%0d=0x%08h, required x%0d=0x%08h",
                   dst_reg, dst_reg_data, mon_exp.r, mon_exp.d);
        end
      end
    end
  end

  // Drive both producer interfaces for the coming clock edge.
  task automatic applyStimulus(input logic av, input logic [RW-1:0] ar, input logic [DW-1:0] ad,
                               input logic mv, input logic [RW-1:0] mr, input logic [DW-1:0] md);
    alu_valid   = av;
    alu_dst_reg = ar;
    alu_data    = ad;
    mem_valid   = mv;
    mem_dst_reg = mr;
    mem_data    = md;
  endtask

  task automatic test_reset();
    #1;
    compared++;
    if ({reg_write_enable, dst_reg, dst_reg_data, busy} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_initial: got we=%0b dst=%0d data=0x%08h busy=%0b, required all 0",
               reg_write_enable, dst_reg, dst_reg_data, busy);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h11);
    sb.push_back({5'd5, 32'h11});
    @(posedge clk) #1;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h22);
    sb.push_back({5'd6, 32'h22});
    @(posedge clk) #1;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    // x6 is on the write port now; asynchronous reset must clear it at once.
    rst = 1'b0;
    #1;
    compared++;
    if ({reg_write_enable, dst_reg, dst_reg_data, busy} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_async: got we=%0b dst=%0d data=0x%08h busy=%0b, required all 0",
               reg_write_enable, dst_reg, dst_reg_data, busy);
    end
    sb.delete();
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if (reg_write_enable !== 1'b0 || busy !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_no_write: got we=%0b busy=%0b, required 0 0", reg_write_enable, busy);
      end
    end
    @(posedge clk) #1;
  endtask

  task automatic test_single_alu();
    applyStimulus(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    #1;
    compared++;
    if (alu_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL single_alu_ready: got %0b, required 1", alu_ready);
    end
    sb.push_back({5'd3, 32'hDEADBEEF});
    @(posedge clk) #1;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    compared++;
    if (reg_write_enable !== 1'b1 || dst_reg !== 5'd3 || dst_reg_data !== 32'hDEADBEEF || busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL single_alu_write: got we=%0b x%0d=0x%08h busy=%0b, required 1 x3=0xdeadbeef 1",
               reg_write_enable, dst_reg, dst_reg_data, busy);
    end
    @(posedge clk) #1;
    compared++;
    if (reg_write_enable !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL single_alu_pulse: got we=%0b busy=%0b, required 0 0", reg_write_enable, busy);
    end
  endtask

  task automatic test_contention();
    applyStimulus(1'b1, 5'd4, 32'h1, 1'b1, 5'd7, 32'h2);
    #1;
    compared++;
    if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL contention_ready: got mem=%0b alu=%0b, required 1 0", mem_ready, alu_ready);
    end
    sb.push_back({5'd7, 32'h2});
    @(posedge clk) #1;
    applyStimulus(1'b1, 5'd4, 32'h1, 1'b0, 5'd0, 32'd0);
    #1;
    compared++;
    if (alu_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL contention_alu_next: got alu_ready=%0b, required 1", alu_ready);
    end
    sb.push_back({5'd4, 32'h1});
    @(posedge clk) #1;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clk) #1;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, RW'(10 + i), 32'hA0 + 32'(i));
      #1;
      compared++;
      if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL backpressure_ready[%0d]: got mem=%0b alu=%0b, required 1 0", i, mem_ready, alu_ready);
      end
      if (i > 0) begin
        compared++;
        if (reg_write_enable !== 1'b1 || busy !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL backpressure_stream[%0d]: got we=%0b busy=%0b, required 1 1", i, reg_write_enable, busy);
        end
      end
      sb.push_back({RW'(10 + i), 32'hA0 + 32'(i)});
      @(posedge clk) #1;
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clk) #1;
    compared++;
    if (reg_write_enable !== 1'b0 || busy !== 1'b0 || sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL backpressure_drain: got we=%0b busy=%0b pending=%0d, required 0 0 0",
               reg_write_enable, busy, sb.size());
    end
  endtask

  task automatic test_x0_drop();
    applyStimulus(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0);
    #1;
    compared++;
    if (alu_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL x0_ready: got %0b, required 1", alu_ready);
    end
    @(posedge clk) #1;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (reg_write_enable !== 1'b0 || busy !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL x0_dropped[%0d]: got we=%0b busy=%0b, required 0 0", i, reg_write_enable, busy);
      end
      @(posedge clk) #1;
    end
  endtask

  task automatic test_forwarding();
    fwd_reg_1 = 5'd9;
    fwd_reg_2 = 5'd0;
    applyStimulus(1'b1, 5'd9, 32'hA, 1'b0, 5'd0, 32'd0);
    #1;
    compared++;
    if (fwd_hit_1 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL fwd_same_cycle: got hit1=%0b, required 0", fwd_hit_1);
    end
    sb.push_back({5'd9, 32'hA});
    @(posedge clk) #1;
    applyStimulus(1'b1, 5'd9, 32'hB, 1'b0, 5'd0, 32'd0);
    #1;
    compared++;
    if (fwd_hit_1 !== FWD || fwd_data_1 !== (FWD ? 32'hA : 32'h0)) begin
      mismatched++;
      $display("[TB] FAIL fwd_older: got hit1=%0b data1=0x%08h, required %0b 0x%08h",
               fwd_hit_1, fwd_data_1, FWD, FWD ? 32'hA : 32'h0);
    end
    sb.push_back({5'd9, 32'hB});
    @(posedge clk) #1;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    compared++;
    if (fwd_hit_1 !== FWD || fwd_data_1 !== (FWD ? 32'hB : 32'h0) || fwd_hit_2 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL fwd_younger: got hit1=%0b data1=0x%08h hit2=%0b, required %0b 0x%08h 0",
               fwd_hit_1, fwd_data_1, fwd_hit_2, FWD, FWD ? 32'hB : 32'h0);
    end
    fwd_reg_2 = 5'd9;
    #1;
    compared++;
    if (fwd_hit_2 !== FWD || fwd_data_2 !== (FWD ? 32'hB : 32'h0)) begin
      mismatched++;
      $display("[TB] FAIL fwd_port2: got hit2=%0b data2=0x%08h, required %0b 0x%08h",
               fwd_hit_2, fwd_data_2, FWD, FWD ? 32'hB : 32'h0);
    end
    @(posedge clk) #1;
    compared++;
    if (fwd_hit_1 !== 1'b0 || fwd_hit_2 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL fwd_retired: got hit1=%0b hit2=%0b, required 0 0", fwd_hit_1, fwd_hit_2);
    end
    fwd_reg_1 = 5'd0;
    fwd_reg_2 = 5'd0;
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_contention();
    test_backpressure();
    test_x0_drop();
    test_forwarding();
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_empty: got %0d pending writes, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
